// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared types and constants for the pipeline hazard controller:
//   - hz_state_e : sequencing FSM states (RUN, DMEM_WAIT, IMEM_WAIT)
//   - FWD_*      : execute-stage ALU operand forward selects
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        IMEM_WAIT = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_W  = 2'b01;  // operand from writeback result
    localparam logic [1:0] FWD_M  = 2'b10;  // operand from memory-stage ALU result

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// fwd_unit
//   Forward select for one execute-stage source operand. Compares the
//   source register against the M and W write ports; the M stage holds the
//   younger result and wins when both match. x0 is never forwarded.
// Ports:
//   rs_i                      execute-stage source register
//   rd_m_i, regwrite_m_i      memory-stage write port
//   rd_w_i, regwrite_w_i      writeback-stage write port
//   fwd_o                     operand select (FWD_RF / FWD_W / FWD_M)
module fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rd_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       regwrite_m_i,
    input  logic       regwrite_w_i,
    output logic [1:0] fwd_o
);

    logic rs_nz;
    assign rs_nz = (rs_i != 5'd0);

    always_comb begin
        fwd_o = FWD_RF;
        if (rs_nz && regwrite_m_i && (rs_i == rd_m_i)) begin
            fwd_o = FWD_M;
        end else if (rs_nz && regwrite_w_i && (rs_i == rd_w_i)) begin
            fwd_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Central hazard/sequencing controller for a 5-stage RV32I pipeline.
//   Produces zero-latency stall/flush controls for PC, F/D, D/E, E/M, M/W,
//   execute-stage forward selects, a memory-wait watchdog with a sticky
//   error flag, and saturating stall/flush event counters.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   rs1_d, rs2_d                    decode-stage sources (load-use check)
//   rs1_e, rs2_e, rd_e, load_e      execute-stage operands / load flag
//   rd_m, regwrite_m, rd_w, regwrite_w  write ports used for forwarding
//   pcsrc_e                         taken branch/jump resolved in E
//   imem_ready, dmem_req_m, dmem_ready  memory handshakes
//   stall_*/flush_*                 pipeline register controls
//   forward_a_e, forward_b_e        ALU operand selects
//   stall_cnt, flush_cnt            saturating event counters
//   err_timeout                     sticky memory-wait timeout
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic [4:0]       rd_m,
    input  logic [4:0]       rd_w,
    input  logic             regwrite_m,
    input  logic             regwrite_w,
    input  logic             load_e,
    input  logic             pcsrc_e,
    input  logic             imem_ready,
    input  logic             dmem_req_m,
    input  logic             dmem_ready,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             stall_e,
    output logic             flush_e,
    output logic             stall_m,
    output logic             flush_w,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             err_timeout
);

    localparam int              WC_W = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WT   = WC_W'(WAIT_TIMEOUT);

    hz_state_e        state_q, state_d;
    logic [WC_W-1:0]  wait_ctr_q, wait_ctr_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             err_q, err_d;

    logic dstall, branch, lu, istall;
    logic [1:0] fwd_a, fwd_b;

    // ---------------- forwarding ----------------
    fwd_unit u_fwd_a (
        .rs_i         (rs1_e),
        .rd_m_i       (rd_m),
        .rd_w_i       (rd_w),
        .regwrite_m_i (regwrite_m),
        .regwrite_w_i (regwrite_w),
        .fwd_o        (fwd_a)
    );

    fwd_unit u_fwd_b (
        .rs_i         (rs2_e),
        .rd_m_i       (rd_m),
        .rd_w_i       (rd_w),
        .regwrite_m_i (regwrite_m),
        .regwrite_w_i (regwrite_w),
        .fwd_o        (fwd_b)
    );

    assign forward_a_e = rst_n ? fwd_a : FWD_RF;
    assign forward_b_e = rst_n ? fwd_b : FWD_RF;

    // ---------------- hazard events ----------------
    assign dstall = dmem_req_m & ~dmem_ready;
    assign branch = pcsrc_e;
    assign lu     = load_e & (rd_e != 5'd0) & ((rd_e == rs1_d) | (rd_e == rs2_d));
    assign istall = ~imem_ready;

    // Priority chain. A data stall freezes everything up to M (including a
    // resolved branch in E, which is acted on once the stall lifts) and
    // drains M/W with a bubble. A branch overrides load-use and fetch
    // stalls because the instructions behind it are being squashed anyway.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        stall_e = 1'b0;
        flush_e = 1'b0;
        stall_m = 1'b0;
        flush_w = 1'b0;
        if (rst_n) begin
            if (dstall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (branch) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lu) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end else if (istall) begin
                stall_f = 1'b1;
                flush_d = 1'b1;
            end
        end
    end

    // ---------------- sequencing FSM / watchdog ----------------
    always_comb begin
        state_d    = RUN;
        wait_ctr_d = '0;
        err_d      = err_q;

        if (dstall) begin
            state_d = DMEM_WAIT;
        end else if (istall && !branch) begin
            state_d = IMEM_WAIT;
        end

        // Counter is zero whenever state_q is RUN, so entering a wait
        // episode starts the count at one.
        if (state_d != RUN) begin
            if (state_q == RUN) begin
                wait_ctr_d = WC_W'(1);
            end else if (wait_ctr_q < WT) begin
                wait_ctr_d = wait_ctr_q + WC_W'(1);
            end else begin
                wait_ctr_d = wait_ctr_q;
            end
            if (wait_ctr_d >= WT) begin
                err_d = 1'b1;
            end
        end
    end

    // ---------------- performance counters ----------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((stall_f | stall_d) && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (branch && !dstall && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_ctr_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_ctr_q  <= wait_ctr_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            err_q       <= err_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Table-driven check of the hazard controller. Two instances share all
//   inputs: a 32-bit-counter one and a 3-bit-counter one (to reach counter
//   saturation quickly); both use a wait timeout of 4.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       regwrite_m, regwrite_w, load_e, pcsrc_e, imem_ready, dmem_req_m, dmem_ready;
    logic       stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_w;
    logic [1:0] forward_a_e, forward_b_e;
    logic [31:0] stall_cnt, flush_cnt;
    logic       err_timeout;
    // second instance outputs
    logic       s2_sf, s2_sd, s2_fd, s2_se, s2_fe, s2_sm, s2_fw;
    logic [1:0] s2_fa, s2_fb;
    logic [2:0] stall_cnt2, flush_cnt2;
    logic       err2;

    hazard_ctrl #(.CNT_W(32), .WAIT_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .regwrite_m(regwrite_m), .regwrite_w(regwrite_w), .load_e(load_e),
        .pcsrc_e(pcsrc_e), .imem_ready(imem_ready), .dmem_req_m(dmem_req_m),
        .dmem_ready(dmem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .stall_e(stall_e),
        .flush_e(flush_e), .stall_m(stall_m), .flush_w(flush_w),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .err_timeout(err_timeout)
    );

    hazard_ctrl #(.CNT_W(3), .WAIT_TIMEOUT(4)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .regwrite_m(regwrite_m), .regwrite_w(regwrite_w), .load_e(load_e),
        .pcsrc_e(pcsrc_e), .imem_ready(imem_ready), .dmem_req_m(dmem_req_m),
        .dmem_ready(dmem_ready),
        .stall_f(s2_sf), .stall_d(s2_sd), .flush_d(s2_fd), .stall_e(s2_se),
        .flush_e(s2_fe), .stall_m(s2_sm), .flush_w(s2_fw),
        .forward_a_e(s2_fa), .forward_b_e(s2_fb),
        .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2), .err_timeout(err2)
    );

    // ctl packing: {stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_w}
    // flags packing: {regwrite_m, regwrite_w, load_e, pcsrc_e, imem_ready, dmem_req_m, dmem_ready}
    typedef struct {
        logic       rst_n;
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        logic [6:0] flags;
        logic [6:0] ctl;
        logic [1:0] fa, fb;
    } vec_t;

    typedef struct {
        string      name;
        logic [6:0] ctl;
        logic [1:0] fa, fb;
    } exp_t;

    exp_t    sbq[$];
    int      checks   = 0;
    int      failures = 0;
    longint  exp_stall = 0;
    longint  exp_flush = 0;
    vec_t    tbl[16];

    function automatic vec_t mkv(input logic r, input logic [4:0] a_rs1_d, a_rs2_d,
                                 a_rs1_e, a_rs2_e, a_rd_e, a_rd_m, a_rd_w,
                                 input logic [6:0] fl, input logic [6:0] c,
                                 input logic [1:0] xa, xb);
        vec_t v;
        v.rst_n = r;
        v.rs1_d = a_rs1_d; v.rs2_d = a_rs2_d; v.rs1_e = a_rs1_e; v.rs2_e = a_rs2_e;
        v.rd_e  = a_rd_e;  v.rd_m  = a_rd_m;  v.rd_w  = a_rd_w;
        v.flags = fl; v.ctl = c; v.fa = xa; v.fb = xb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    function automatic longint sat7(input longint x);
        return (x > 7) ? 7 : x;
    endfunction

    task automatic check_regs(input string nm, input logic exp_err);
        chk({nm, ".stall_cnt"},  stall_cnt,  exp_stall);
        chk({nm, ".flush_cnt"},  flush_cnt,  exp_flush);
        chk({nm, ".stall_cnt2"}, stall_cnt2, sat7(exp_stall));
        chk({nm, ".flush_cnt2"}, flush_cnt2, sat7(exp_flush));
        chk({nm, ".err"},        err_timeout, exp_err);
        chk({nm, ".err2"},       err2,        exp_err);
    endtask

    // Drive one cycle of inputs, queue the expected response, compare it
    // mid-cycle, then advance the counter model across the clock edge.
    task automatic step(input vec_t v, input string nm);
        exp_t e;
        logic dst;
        rst_n = v.rst_n;
        rs1_d = v.rs1_d; rs2_d = v.rs2_d; rs1_e = v.rs1_e; rs2_e = v.rs2_e;
        rd_e  = v.rd_e;  rd_m  = v.rd_m;  rd_w  = v.rd_w;
        {regwrite_m, regwrite_w, load_e, pcsrc_e, imem_ready, dmem_req_m, dmem_ready} = v.flags;
        e.name = nm; e.ctl = v.ctl; e.fa = v.fa; e.fb = v.fb;
        sbq.push_back(e);
        @(negedge clk);
        if (sbq.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sbq.pop_front();
            chk({e.name, ".ctl"}, {stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_w}, e.ctl);
            chk({e.name, ".fa"},  forward_a_e, e.fa);
            chk({e.name, ".fb"},  forward_b_e, e.fb);
            chk({e.name, ".ctl2"}, {s2_sf, s2_sd, s2_fd, s2_se, s2_fe, s2_sm, s2_fw}, e.ctl);
        end
        @(posedge clk);
        dst = v.flags[1] & ~v.flags[0];
        if (!v.rst_n) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (v.ctl[6] | v.ctl[5]) exp_stall++;
            if (v.flags[3] && !dst)  exp_flush++;
        end
        #1;
    endtask

    vec_t vD, vDB, vBR, vI, vR, vX;

    initial begin
        //             rst rs1d rs2d rs1e rs2e rde rdm rdw  flags        ctl         fa     fb
        tbl[0]  = mkv(0,  0,  0,  5,  0,  0,  5,  0, 7'b1001010, 7'b0000000, 2'b00, 2'b00);
        tbl[1]  = mkv(1,  0,  0,  5,  3,  0,  5,  5, 7'b1100100, 7'b0000000, 2'b10, 2'b00);
        tbl[2]  = mkv(1,  0,  0,  5,  3,  0,  0,  5, 7'b1100100, 7'b0000000, 2'b01, 2'b00);
        tbl[3]  = mkv(1,  0,  0,  0,  5,  0,  0,  5, 7'b1100100, 7'b0000000, 2'b00, 2'b01);
        tbl[4]  = mkv(1,  0,  0,  0,  5,  0,  5,  5, 7'b0100100, 7'b0000000, 2'b00, 2'b01);
        tbl[5]  = mkv(1,  0,  0,  9,  9,  0,  9,  9, 7'b1100100, 7'b0000000, 2'b10, 2'b10);
        tbl[6]  = mkv(1,  0,  7,  0,  0,  7,  0,  0, 7'b0010100, 7'b1100100, 2'b00, 2'b00);
        tbl[7]  = mkv(1,  0,  7,  0,  0,  7,  0,  0, 7'b0000100, 7'b0000000, 2'b00, 2'b00);
        tbl[8]  = mkv(1,  0,  3,  0,  0,  0,  0,  0, 7'b0010100, 7'b0000000, 2'b00, 2'b00);
        tbl[9]  = mkv(1,  7,  0,  0,  0,  7,  0,  0, 7'b0010000, 7'b1100100, 2'b00, 2'b00);
        tbl[10] = mkv(1,  0,  0,  0,  0,  0,  0,  0, 7'b0000000, 7'b1010000, 2'b00, 2'b00);
        tbl[11] = mkv(1,  7,  0,  0,  0,  7,  0,  0, 7'b0011000, 7'b0010100, 2'b00, 2'b00);
        tbl[12] = mkv(1,  0,  0,  0,  0,  0,  0,  0, 7'b0000110, 7'b1101011, 2'b00, 2'b00);
        tbl[13] = mkv(1,  0,  0,  0,  0,  0,  0,  0, 7'b0000111, 7'b0000000, 2'b00, 2'b00);
        tbl[14] = mkv(1,  7,  0,  0,  0,  7,  0,  0, 7'b0010010, 7'b1101011, 2'b00, 2'b00);
        tbl[15] = mkv(1,  0,  0,  5,  0,  0,  0,  5, 7'b1000100, 7'b0000000, 2'b00, 2'b00);

        // reset with hazards present: outputs quiet, registers cleared
        step(tbl[0], "reset");
        check_regs("after_reset", 1'b0);

        for (int i = 1; i < 16; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end
        check_regs("after_table", 1'b0);

        // data stall holding a taken branch, then release
        vDB = mkv(1, 0, 0, 0, 0, 0, 0, 0, 7'b0001110, 7'b1101011, 2'b00, 2'b00);
        vBR = mkv(1, 0, 0, 0, 0, 0, 0, 0, 7'b0001111, 7'b0010100, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) step(vDB, $sformatf("dstall_br%0d", i));
        step(vBR, "br_release");
        check_regs("after_dstall_br", 1'b0);

        // fetch wait watchdog: sets on the 4th consecutive wait cycle
        vI = mkv(1, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 7'b1010000, 2'b00, 2'b00);
        vR = mkv(1, 0, 0, 0, 0, 0, 0, 0, 7'b0000100, 7'b0000000, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) step(vI, $sformatf("iwait%0d", i));
        check_regs("iwait3", 1'b0);
        step(vI, "iwait3");
        check_regs("iwait4", 1'b1);
        step(vR, "irelease0");
        step(vR, "irelease1");
        check_regs("err_sticky", 1'b1);

        // reset pulse in the middle of a data wait
        vD = mkv(1, 0, 0, 0, 0, 0, 0, 0, 7'b0000110, 7'b1101011, 2'b00, 2'b00);
        vX = mkv(0, 0, 0, 0, 0, 0, 0, 0, 7'b0000110, 7'b0000000, 2'b00, 2'b00);
        step(vD, "dwait0");
        step(vD, "dwait1");
        step(vX, "rst_mid_wait");
        check_regs("after_rst_mid", 1'b0);
        step(vR, "post_rst_run");
        check_regs("post_rst_run", 1'b0);

        // a fresh wait episode after reset must not inherit the old count
        for (int i = 0; i < 3; i++) step(vI, $sformatf("iwait_post%0d", i));
        check_regs("iwait_post", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RV32I pipeline.
- Generates stall (enable) and flush (clear) controls for the F/D, D/E, E/M and M/W pipeline registers and the PC register.
- Generates the execute-stage forwarding selects.
- Tracks instruction- and data-memory wait states, flags stuck memories, and keeps saturating stall/flush performance counters.

Parameters:
CNT_W, 32, width of the performance counters
WAIT_TIMEOUT, 255, consecutive wait cycles in one wait episode after which err_timeout sets

Ports:
clk  in  1  clock
rst_n  in  1  reset
rs1_d  in  5  decode-stage source register 1
rs2_d  in  5  decode-stage source register 2
rs1_e  in  5  execute-stage source register 1
rs2_e  in  5  execute-stage source register 2
rd_e  in  5  execute-stage destination
rd_m  in  5  memory-stage destination
rd_w  in  5  writeback-stage destination
regwrite_m  in  1  memory-stage instruction writes rd
regwrite_w  in  1  writeback-stage instruction writes rd
load_e  in  1  execute-stage instruction is a load
pcsrc_e  in  1  taken branch/jump resolved in E
imem_ready  in  1  fetch data valid this cycle
dmem_req_m  in  1  memory-stage access in progress
dmem_ready  in  1  data memory completes this cycle
stall_f  out  1  hold PC
stall_d  out  1  hold F/D register (its enable = ~stall_d)
flush_d  out  1  clear F/D register
stall_e  out  1  hold D/E register
flush_e  out  1  clear D/E register
stall_m  out  1  hold E/M register
flush_w  out  1  clear M/W register
forward_a_e  out  2  ALU operand A select
forward_b_e  out  2  ALU operand B select
stall_cnt  out  CNT_W  cycles with stall_f or stall_d asserted
flush_cnt  out  CNT_W  cycles with a branch flush issued
err_timeout  out  1  sticky memory-wait timeout

Behaviour:
- Clock and reset: one clock clk. Reset rst_n is synchronous, active-low.
- Reset values: state=RUN, wait_ctr=0, stall_cnt=0, flush_cnt=0, err_timeout=0.
- While rst_n=0, every stall/flush output is 0 and both forward selects are 2'b00.
- Stall, flush and forward outputs are combinational from the current inputs and state, with zero latency. Counters, state and err_timeout are registered.
- Forwarding, for each of rs1_e and rs2_e:
  - 2'b10 if rs != 0, rs == rd_m and regwrite_m.
  - Else 2'b01 if rs != 0, rs == rd_w and regwrite_w.
  - Else 2'b00.
  - The M-stage match has priority over the W-stage match.
- Event conditions:
  - dstall = dmem_req_m & ~dmem_ready.
  - branch = pcsrc_e.
  - lu = load_e & rd_e != 0 & (rd_e == rs1_d | rd_e == rs2_d).
  - istall = ~imem_ready.
- Output priority, highest first:
  1. dstall: stall_f = stall_d = stall_e = stall_m = 1, flush_w = 1, all other flushes 0. A branch sitting in E stays frozen and is acted on after the stall lifts.
  2. branch: flush_d = flush_e = 1, stall_f = 0 (the PC loads the target and abandons any pending fetch), stall_d = 0.
  3. lu: stall_f = stall_d = 1, flush_e = 1. This also covers lu together with istall.
  4. istall: stall_f = 1, flush_d = 1 (a bubble enters decode).
  5. Otherwise: all stall/flush outputs 0.
- FSM states: RUN, DMEM_WAIT, IMEM_WAIT.
  - Next state is DMEM_WAIT if dstall.
  - Else IMEM_WAIT if istall & ~branch.
  - Else RUN.
- wait_ctr:
  - Increments each cycle the next state is a wait state, saturating at WAIT_TIMEOUT.
  - Clears whenever the next state is RUN.
  - When it would reach WAIT_TIMEOUT, err_timeout sets and holds until reset. Pipeline behaviour is unaffected.
- Counters:
  - stall_cnt increments in any cycle where stall_f | stall_d.
  - flush_cnt increments in any cycle with branch & ~dstall.
  - Both saturate at all-ones.
- Reset asserted mid-wait: the next cycle returns to RUN with counters cleared.

Decomposition:
- Shared package holds:
  - the FSM state enum (RUN, DMEM_WAIT, IMEM_WAIT);
  - forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
- One natural sub-module: fwd_unit, combinational and instantiated twice (operands A and B). It compares one source register against the rd_m/rd_w write ports.

Test Plan:
- Back-to-back ALU ops, with rd_m=5/regwrite_m=1 and rd_w=5/regwrite_w=1, rs1_e=5 -> forward_a_e=2'b10. Then rd_m=0 -> 2'b01. Then rs1_e=0 -> 2'b00.
- Load-use: load_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle; stall_cnt increments by 1. With rd_e=0 -> no stall.
- Branch taken coincident with load-use and imem_ready=0 -> flush_d=flush_e=1, stall_f=stall_d=0; flush_cnt increments by 1.
- dmem_req_m=1, dmem_ready=0 for 3 cycles while pcsrc_e=1:
  - all stalls and flush_w=1 for 3 cycles, flush_d=0;
  - on the cycle dmem_ready=1, flush_d=flush_e=1;
  - stall_cnt increments by 3 during the wait.
- WAIT_TIMEOUT=4, imem_ready held 0 -> err_timeout sets when wait_ctr reaches 4 (4th consecutive wait cycle) and stays set after imem_ready=1. Only rst_n=0 clears it.
- Reset pulse during DMEM_WAIT -> outputs 0 while rst_n=0; the next cycle shows state RUN and counters 0.
